// File: rtl/signed_avg_pkg.sv
// Shared types and helpers for the signed moving-average filter.
package signed_avg_pkg;

    typedef enum logic {FILL, RUN} avg_state_t;

    // The running sum needs LOG2_WIN extra bits so a full window of extreme samples cannot wrap.
    function automatic int acc_width(input int width, input int log2_win);
        return width + log2_win;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Ring of the last DEPTH accepted samples. It owns the write pointer and presents the oldest
// entry, which is the one about to be overwritten, on an asynchronous read port.
module sample_ring_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en_i,
    input  logic signed [WIDTH-1:0] wr_data_i,
    output logic signed [WIDTH-1:0] oldest_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        ptr_q, ptr_d;

    always_comb begin
        ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the storage is cleared on reset on purpose. The zero-filled window is
            // what lets the filter produce correct averages before it has seen DEPTH samples.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
            ptr_q        <= ptr_d;
        end
    end

    assign oldest_o = mem_q[ptr_q];

endmodule

// File: rtl/signed_moving_avg.sv
// Streaming boxcar filter over 2**LOG2_WIN signed samples. Define MOVAVG_ROUND_EN to round
// half toward +inf. When it is not defined, the result is the floor of the mean.
module signed_moving_avg
    import signed_avg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    win_full
);

    localparam int ACC_W = acc_width(WIDTH, LOG2_WIN);
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int CNT_W = (LOG2_WIN > 0) ? LOG2_WIN : 1;

    avg_state_t              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_data_q, avg;
    logic signed [WIDTH-1:0] oldest;
    logic                    accept;

    // There is no skid buffer, so downstream back-pressure reaches in_ready combinationally.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    sample_ring_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (WIN)
    ) u_ring (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .oldest_o  (oldest)
    );

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = sum_q + ACC_W'(in_data) - ACC_W'(oldest);
        end
    end

`ifdef MOVAVG_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'((2 ** LOG2_WIN) / 2);
    logic signed [ACC_W:0] rnd_sum;

    assign rnd_sum = (ACC_W + 1)'(sum_d) + RND;
    assign avg     = WIDTH'(rnd_sum >>> LOG2_WIN);
`else
    assign avg     = WIDTH'(sum_d >>> LOG2_WIN);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (accept && state_q == FILL) begin
            if (count_q == CNT_W'(WIN - 1)) begin
                state_d = RUN;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= FILL;
            count_q     <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= avg;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign win_full  = (state_q == RUN);

endmodule

// File: tb/tb_signed_moving_avg.sv
// Bench for signed_moving_avg with a four-sample window. It runs directed corner cases and then
// randomised handshakes, and checks them against a queue-based average model.
module tb_signed_moving_avg;

    localparam int WIDTH    = 16;
    localparam int LOG2_WIN = 2;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] out_data;
    logic                    win_full;

    int n_vec = 0;
    int n_miscmp = 0;

    int win_q[$] = '{0, 0, 0, 0};
    int n_acc = 0;
    int n_in = 0;
    int n_out = 0;
    bit exp_valid = 1'b0;
    int exp_data = 0;

    always #5 clk = ~clk;

    signed_moving_avg #(
        .WIDTH    (WIDTH),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .win_full  (win_full)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Mean of the last four accepted samples: floor, or round half up when rounding is built in.
    function automatic int model_avg();
        int s = 0;
        foreach (win_q[i]) s += win_q[i];
`ifdef MOVAVG_ROUND_EN
        s += 2;
`endif
        return (s >= 0) ? s / 4 : -((-s + 3) / 4);
    endfunction

    // One clock cycle: check in_ready, let the edge pass, update the model, check the outputs.
    task automatic tick();
        bit exp_ready, acc, take;
        #1;
        exp_ready = !exp_valid || out_ready;
        check("in_ready", in_ready, exp_ready);
        acc  = rstn && in_valid && exp_ready;
        take = rstn && out_valid && out_ready;
        @(posedge clk);
        #1;
        if (!rstn) begin
            win_q = '{0, 0, 0, 0};
            n_acc = 0;
            n_in = 0;
            n_out = 0;
            exp_valid = 1'b0;
            exp_data = 0;
        end else begin
            if (take) n_out++;
            if (acc) begin
                void'(win_q.pop_front());
                win_q.push_back(int'(in_data));
                n_acc++;
                n_in++;
                exp_valid = 1'b1;
                exp_data = model_avg();
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
        check("out_valid", out_valid, exp_valid);
        check("out_data", out_data, exp_data);
        check("win_full", win_full, n_acc >= 4);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic send(input int x);
        in_valid = 1'b1;
        in_data = WIDTH'(x);
        tick();
        in_valid = 1'b0;
    endtask

    int ramp_in[5]  = '{4, 8, 12, 16, 20};
    int ramp_out[5] = '{1, 3, 6, 10, 14};
    int neg_in[5]   = '{-5, -2, -4, -6, -8};
`ifdef MOVAVG_ROUND_EN
    int neg_out[5]  = '{-1, 0, -1, -1, -2};
`else
    int neg_out[5]  = '{-2, -1, -1, -2, -2};
`endif

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_full", win_full, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(ramp_in[i]);
            check("ramp_out", out_data, ramp_out[i]);
            check("ramp_full", win_full, i >= 3);
        end

        for (int i = 0; i < 5; i++) begin
            do_reset();
            send(neg_in[i]);
            check("neg_round", out_data, neg_out[i]);
        end

        do_reset();
        repeat (4) send(32767);
        check("max_out", out_data, 32767);
        repeat (4) send(-32768);
        check("min_out", out_data, -32768);

        do_reset();
        out_ready = 1'b0;
        send(8);
        check("bp_first", out_data, 2);
        in_valid = 1'b1;
        in_data = 16'sd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ready", in_ready, 0);
            check("bp_hold", out_data, 2);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_next", out_data, 5);

        do_reset();
        send(100);
        send(200);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_full", win_full, 0);
        send(8);
        check("mid_rst_out", out_data, 2);
        check("mid_rst_full2", win_full, 0);

        do_reset();
        for (int i = 0; i < 10000; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            case ($urandom % 8)
                0:       in_data = 16'sh7fff;
                1:       in_data = 16'sh8000;
                default: in_data = WIDTH'($urandom);
            endcase
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("io_count", n_out + int'(exp_valid), n_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
